alu_accum_seq: RTL and testbench
================================

Name: alu_accum_seq

Overview:
- Parametrised, sequential successor to the 8-bit one-hot-select ALU.
- Holds the last result as an accumulator and runs commands through a 4-state FSM with a start/busy/done handshake.
- Multiply is iterative shift-add; all other operations take one cycle.
- Sits between operand/opcode sources and display/next-stage logic; exposes FSM state for debug benches.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- RESET_VAL, 0, value loaded into the accumulator by a reset-mode command.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- on  input  1  enable; 0 forces OFF.
- start  input  1  command request, sampled in IDLE only.
- in_sel  input  3  one-hot mode: 100 reset accumulator, 010 load (A=num1), 001 persist (A=accumulator).
- out_sel  input  7  one-hot op: 1000000 MUL, 0100000 ADD, 0010000 SUB, 0001000 AND, 0000100 OR, 0000010 XOR, 0000001 NOT A.
- num1  input  WIDTH  operand A in load mode.
- num2  input  WIDTH  operand B.
- out  output  WIDTH  accumulator / result register.
- ovf  output  1  overflow flag of the last completed op.
- busy  output  1  high in EXEC.
- done  output  1  one-cycle pulse in DONE.
- curr_state  output  2  registered FSM state.
- next_state  output  2  combinational next state.

Behaviour:
- Clock, reset and state encoding:
  - Single clock clk; rst is synchronous, active-high.
  - On rst: out=0, ovf=0, busy=0, done=0, curr_state=OFF.
  - rst takes priority over everything, including mid-operation.
  - State encoding: OFF=00, IDLE=01, EXEC=10, DONE=11.
- State transitions:
  - OFF -> IDLE when on=1.
  - Any state -> OFF when on=0. An in-flight op is aborted, out/ovf are held and no done pulse is issued.
  - IDLE -> EXEC when start=1 and in_sel is one-hot. At that edge, capture the operands (A per in_sel, B=num2), in_sel and out_sel.
  - A start with non-one-hot in_sel is ignored and the FSM stays IDLE.
  - EXEC -> DONE when the op completes: after 1 cycle for non-MUL and for reset mode, after WIDTH cycles for MUL.
  - DONE -> IDLE unconditionally.
  - start is ignored outside IDLE. Input changes after capture have no effect.
- Timing:
  - Start accepted at edge k: out/ovf update at edge k+1 (MUL: k+WIDTH).
  - done=1 for exactly the following cycle; busy=1 exactly while curr_state=EXEC.
- Arithmetic (unsigned, result truncated to WIDTH):
  - ADD: ovf = carry out.
  - SUB: ovf = borrow (A<B).
  - MUL: 2*WIDTH-bit product; ovf = upper half nonzero; out = lower half.
  - AND/OR/XOR/NOT: ovf=0.
- Special commands:
  - Reset mode: out=RESET_VAL, ovf=0; out_sel is ignored.
  - out_sel not one-hot (incl. zero): out unchanged, ovf=0, done still pulses.
- MUL datapath:
  - Internal product/multiplicand/counter registers only.
  - out is not written until completion, so out stays stable during EXEC.

Optional Feature:
- Macro: ALU_SATURATE_EN.
- Defined:
  - ADD/MUL overflow drives out to all-ones.
  - SUB borrow drives out to 0.
  - ovf is still set.
- Undefined: results wrap modulo 2^WIDTH.
- Logic ops are unaffected in both builds.

Test Plan:
- Multiply 1x2: rst, on=1, start with load, MUL, num1=1, num2=2 -> curr_state 00->01->10 (8 cycles)->11->01; out=2, ovf=0, single done pulse.
- Multiply overflow: load MUL 0x57 x 0x1A (=0x08D6) -> out=0xD6, ovf=1; with ALU_SATURATE_EN out=0xFF.
- Persist chain: load ADD 1+2 -> out=3; then persist ADD num1=0x55, num2=4 -> out=7 (num1 ignored); then persist SUB num2=9 -> out=0xFE, ovf=1 (saturate build: 0x00).
- Reset mode and ignored starts:
  - in_sel=100 with start -> out=RESET_VAL, ovf=0 one cycle later.
  - A second start pulsed during busy -> no extra done.
- Abort and reset:
  - on=0 on the 3rd EXEC cycle of a MUL -> OFF next edge, out holds the prior value, no done.
  - rst asserted mid-MUL -> out=0 and curr_state=00 at the next edge.
- Illegal selects:
  - out_sel=0000000 -> out unchanged, ovf=0, done pulses.
  - in_sel=011 with start -> FSM stays IDLE.

Source files
------------

// File: rtl/alu_accum_seq.sv
// Sequential accumulator ALU: one-hot mode/op select, start/busy/done FSM.
// Define ALU_SATURATE_EN to clamp ADD/MUL overflow to all-ones, SUB borrow to 0.
module alu_accum_seq #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic             start,
  input  logic [2:0]       in_sel,
  input  logic [6:0]       out_sel,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output logic [1:0]       curr_state,
  output logic [1:0]       next_state
);

  localparam logic [1:0] OFF  = 2'b00;
  localparam logic [1:0] IDLE = 2'b01;
  localparam logic [1:0] EXEC = 2'b10;
  localparam logic [1:0] DONE = 2'b11;

  localparam int CW = $clog2(WIDTH);

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [WIDTH-1:0]   out_q;
  logic               ovf_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               rmode_q;
  logic [6:0]         op_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  logic               in_ok;
  logic               op_ok;
  logic               is_mul;
  logic               exec_last;
  logic [WIDTH-1:0]   a_sel;
  logic [2*WIDTH-1:0] prod_nx;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   res;
  logic               res_ovf;

  assign in_ok = (in_sel == 3'b100) ||
                 (in_sel == 3'b010) ||
                 (in_sel == 3'b001);

  assign op_ok = (op_q != 7'd0) &&
                 ((op_q & (op_q - 7'd1)) == 7'd0);

  assign is_mul    = !rmode_q && op_ok && op_q[6];
  assign exec_last = !is_mul || (cnt_q == CW'(WIDTH - 1));

  assign a_sel = in_sel[1] ? num1 : out_q;

  // One shift-add step; on the last step this is the full product.
  assign prod_nx = prod_q + (mplier_q[0] ? mcand_q : '0);

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    if (!on) begin
      state_d = OFF;
    end else begin
      unique case (state_q)
        OFF:  state_d = IDLE;
        IDLE: if (start && in_ok) state_d = EXEC;
        EXEC: if (exec_last) state_d = DONE;
        DONE: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    res     = out_q;
    res_ovf = 1'b0;
    if (rmode_q) begin
      res = RESET_VAL;
    end else if (op_ok) begin
      unique case (1'b1)
        op_q[6]: begin
          res     = prod_nx[WIDTH-1:0];
          res_ovf = |prod_nx[2*WIDTH-1:WIDTH];
        end
        op_q[5]: {res_ovf, res} = sum;
        op_q[4]: begin
          res     = diff[WIDTH-1:0];
          res_ovf = diff[WIDTH];
        end
        op_q[3]: res = a_q & b_q;
        op_q[2]: res = a_q | b_q;
        op_q[1]: res = a_q ^ b_q;
        op_q[0]: res = ~a_q;
        default: ;
      endcase
    end
`ifdef ALU_SATURATE_EN
    if (res_ovf) res = op_q[4] ? '0 : '1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= OFF;
      out_q    <= '0;
      ovf_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rmode_q  <= 1'b0;
      op_q     <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == EXEC) begin
        a_q      <= a_sel;
        b_q      <= num2;
        rmode_q  <= in_sel[2];
        op_q     <= out_sel;
        prod_q   <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, a_sel};
        mplier_q <= num2;
        cnt_q    <= '0;
      end else if (state_q == EXEC) begin
        prod_q   <= prod_nx;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CW'(1);
        // An abort (on=0) leaves the accumulator untouched.
        if (state_d == DONE) begin
          out_q <= res;
          ovf_q <= res_ovf;
        end
      end
    end
  end

  assign out        = out_q;
  assign ovf        = ovf_q;
  assign busy       = (state_q == EXEC);
  assign done       = (state_q == DONE);
  assign curr_state = state_q;
  assign next_state = state_d;

endmodule

// File: tb/tb_alu_accum_seq.sv
// Directed bench for alu_accum_seq (WIDTH=8, RESET_VAL=A5).
// Expectations follow ALU_SATURATE_EN when the bench is built with it.
module tb_alu_accum_seq;

  localparam logic [7:0] RV = 8'hA5;
`ifdef ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [6:0] MUL = 7'b1000000;
  localparam logic [6:0] ADD = 7'b0100000;
  localparam logic [6:0] SUB = 7'b0010000;
  localparam logic [6:0] AND = 7'b0001000;
  localparam logic [6:0] OR  = 7'b0000100;
  localparam logic [6:0] XOR = 7'b0000010;
  localparam logic [6:0] NOT = 7'b0000001;

  localparam logic [2:0] RSTM = 3'b100;
  localparam logic [2:0] LOAD = 3'b010;
  localparam logic [2:0] PERS = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic       on;
  logic       start;
  logic [2:0] in_sel;
  logic [6:0] out_sel;
  logic [7:0] num1;
  logic [7:0] num2;
  logic [7:0] out;
  logic       ovf;
  logic       busy;
  logic       done;
  logic [1:0] curr_state;
  logic [1:0] next_state;

  int n_chk  = 0;
  int n_fail = 0;

  alu_accum_seq #(
    .WIDTH     (8),
    .RESET_VAL (RV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .on         (on),
    .start      (start),
    .in_sel     (in_sel),
    .out_sel    (out_sel),
    .num1       (num1),
    .num2       (num2),
    .out        (out),
    .ovf        (ovf),
    .busy       (busy),
    .done       (done),
    .curr_state (curr_state),
    .next_state (next_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] is, input logic [6:0] os,
                       input logic [7:0] a, input logic [7:0] b);
    start   = 1'b1;
    in_sel  = is;
    out_sel = os;
    num1    = a;
    num2    = b;
    @(negedge clk);
    start   = 1'b0;
    in_sel  = 3'b000;
    out_sel = ADD;
    num1    = ~a;
    num2    = ~b;
  endtask

  task automatic run(input string tag, input logic [2:0] is,
                     input logic [6:0] os, input logic [7:0] a,
                     input logic [7:0] b, input int exp_cyc,
                     input logic [7:0] exp_out, input logic exp_ovf);
    int cyc;
    cyc = 0;
    issue(is, os, a, b);
    check({tag, "_exec"}, 16'(curr_state), 16'(2'b10));
    while (busy && cyc < 40) begin
      check({tag, "_hold"}, 16'(done), 16'd0);
      cyc++;
      @(negedge clk);
    end
    check({tag, "_cyc"}, 16'(cyc), 16'(exp_cyc));
    check({tag, "_st"}, 16'(curr_state), 16'(2'b11));
    check({tag, "_done"}, 16'(done), 16'd1);
    check({tag, "_out"}, 16'(out), 16'(exp_out));
    check({tag, "_ovf"}, 16'(ovf), 16'(exp_ovf));
    @(negedge clk);
    check({tag, "_idle"}, 16'(curr_state), 16'(2'b01));
    check({tag, "_dn0"}, 16'(done), 16'd0);
  endtask

  initial begin
    int dones;
    rst = 1'b1; on = 1'b0; start = 1'b0;
    in_sel = '0; out_sel = '0; num1 = '0; num2 = '0;
    repeat (2) @(negedge clk);
    check("rst_out", 16'(out), 16'd0);
    check("rst_ovf", 16'(ovf), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_st", 16'(curr_state), 16'(2'b00));
    rst = 1'b0;
    @(negedge clk);
    check("off_st", 16'(curr_state), 16'(2'b00));
    on = 1'b1;
    check("off_nx", 16'(next_state), 16'(2'b01));
    @(negedge clk);
    check("on_st", 16'(curr_state), 16'(2'b01));

    run("mul1x2", LOAD, MUL, 8'h01, 8'h02, 8, 8'h02, 1'b0);
    run("mulovf", LOAD, MUL, 8'h57, 8'h1A, 8, SAT ? 8'hFF : 8'hD6, 1'b1);
    run("add12", LOAD, ADD, 8'h01, 8'h02, 1, 8'h03, 1'b0);
    run("padd", PERS, ADD, 8'h55, 8'h04, 1, 8'h07, 1'b0);
    run("psub", PERS, SUB, 8'hAA, 8'h09, 1, SAT ? 8'h00 : 8'hFE, 1'b1);
    run("op0", PERS, 7'b0000000, 8'h11, 8'h22, 1, SAT ? 8'h00 : 8'hFE, 1'b0);
    run("addc", LOAD, ADD, 8'hFF, 8'h01, 1, SAT ? 8'hFF : 8'h00, 1'b1);
    run("op2h", LOAD, 7'b0000011, 8'h11, 8'h22, 1, SAT ? 8'hFF : 8'h00, 1'b0);
    run("and", LOAD, AND, 8'hF0, 8'h3C, 1, 8'h30, 1'b0);
    run("or", LOAD, OR, 8'hF0, 8'h3C, 1, 8'hFC, 1'b0);
    run("xor", LOAD, XOR, 8'hF0, 8'h3C, 1, 8'hCC, 1'b0);
    run("not", LOAD, NOT, 8'hF0, 8'h3C, 1, 8'h0F, 1'b0);
    run("rmode", RSTM, MUL, 8'h12, 8'h34, 1, RV, 1'b0);
    run("pmul", PERS, MUL, 8'h00, 8'h02, 8, SAT ? 8'hFF : 8'h4A, 1'b1);

    // Extra start while busy must not create a second command.
    issue(LOAD, MUL, 8'h03, 8'h05);
    @(negedge clk);
    start = 1'b1; in_sel = LOAD; out_sel = ADD;
    num1 = 8'h40; num2 = 8'h01;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    repeat (20) begin
      dones += int'(done);
      @(negedge clk);
    end
    check("busy_start_dones", 16'(dones), 16'd1);
    check("busy_start_out", 16'(out), 16'h0F);
    check("busy_start_ovf", 16'(ovf), 16'd0);

    start = 1'b1; in_sel = 3'b011; out_sel = ADD;
    @(negedge clk);
    start = 1'b0;
    check("bad_in_st", 16'(curr_state), 16'(2'b01));
    check("bad_in_busy", 16'(busy), 16'd0);
    @(negedge clk);
    check("bad_in_out", 16'(out), 16'h0F);

    issue(LOAD, MUL, 8'h03, 8'h04);
    @(negedge clk);
    @(negedge clk);
    check("abort_exec", 16'(curr_state), 16'(2'b10));
    on = 1'b0;
    dones = 0;
    @(negedge clk);
    check("abort_st", 16'(curr_state), 16'(2'b00));
    check("abort_out", 16'(out), 16'h0F);
    check("abort_ovf", 16'(ovf), 16'd0);
    repeat (10) begin
      dones += int'(done);
      @(negedge clk);
    end
    check("abort_dones", 16'(dones), 16'd0);
    check("abort_hold", 16'(out), 16'h0F);
    on = 1'b1;
    @(negedge clk);
    check("reon_st", 16'(curr_state), 16'(2'b01));

    issue(LOAD, MUL, 8'h05, 8'h05);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_out", 16'(out), 16'd0);
    check("mrst_st", 16'(curr_state), 16'(2'b00));
    check("mrst_busy", 16'(busy), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_idle", 16'(curr_state), 16'(2'b01));

    run("sub93", LOAD, SUB, 8'h09, 8'h03, 1, 8'h06, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
